anton_neopixel_rx: RTL and testbench

Receiver for the WS2812 single-wire stream produced by the NeoPixel transmitter. It samples the serial line with the same 7 MHz clock and classifies each bit by its high-pulse width. Decoded bytes go out on a byte-wide write port in arrival order, addressed from 0, so they can fill a pixel buffer. The block is used for loopback self-test of the transmitter and for snooping downstream of a pixel chain.

---
 rtl/anton_neopixel_rx_if.sv | 19 +
 rtl/anton_neopixel_rx.sv | 220 ++++++++++++++++++++++
 tb/tb_anton_neopixel_rx.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/anton_neopixel_rx_if.sv
// ----------------------------------------------------------------------------
// anton_neopixel_rx_if
// Byte-wide write port that carries decoded WS2812 bytes from the receiver
// into a pixel buffer.
//   pixWrite  one-cycle strobe, pixAddr/pixData valid while high
//   pixAddr   byte address within the current frame (ADDR_W bits)
//   pixData   decoded byte, first received bit in bit 7
// master: the receiver drives the port; slave: the buffer/consumer.
// ----------------------------------------------------------------------------
interface anton_neopixel_rx_if #(
  parameter int ADDR_W = 5
);
  logic              pixWrite;
  logic [ADDR_W-1:0] pixAddr;
  logic [7:0]        pixData;

  modport master (output pixWrite, output pixAddr, output pixData);
  modport slave  (input  pixWrite, input  pixAddr, input  pixData);
endinterface

// File: rtl/anton_neopixel_rx.sv
// ----------------------------------------------------------------------------
// anton_neopixel_rx
// WS2812 single-wire receiver. Samples the serial line on the 7 MHz clock,
// classifies each bit by its high-pulse width and writes assembled bytes
// (MSB first) to a byte-addressed buffer port, starting at address 0 per frame.
//
// Ports:
//   clk7mhz      in   sole clock
//   rstn         in   asynchronous active-low reset
//   neoDataIn    in   serial line, asynchronous to clk7mhz
//   pix          if   write port (pixWrite / pixAddr / pixData), master side
//   frameDone    out  one-cycle pulse when a frame ends on a long low
//   frameBytes   out  bytes stored by the last completed frame
//   rxActive     out  high while a bit is being received (HIGH or LOW state)
//   errOverflow  out  sticky: frame carried more bytes than the buffer holds
//   errGlitch    out  sticky: a high pulse was longer than HIGH_MAX ticks
// ----------------------------------------------------------------------------
module anton_neopixel_rx #(
  parameter  int BUFFER_END    = 31,
  parameter  int RESET_DELAY   = 350,
  parameter  int BIT_THRESHOLD = 4,
  parameter  int HIGH_MAX      = 7,
  localparam int BUFFER_BITS   = $clog2(BUFFER_END + 1)
) (
  input  logic                     clk7mhz,
  input  logic                     rstn,
  input  logic                     neoDataIn,
  anton_neopixel_rx_if.master      pix,
  output logic                     frameDone,
  output logic [BUFFER_BITS:0]     frameBytes,
  output logic                     rxActive,
  output logic                     errOverflow,
  output logic                     errGlitch
);

  localparam logic [1:0] ST_ARM  = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  // highCnt does not count the tick on which the rising edge is seen, so the
  // pulse width at the falling edge is highCnt+1, and while still high in
  // HIGH the width so far is highCnt+2. Thresholds are shifted to match.
  localparam logic [3:0]           BIT_ONE_CNT = 4'(BIT_THRESHOLD - 1);
  localparam logic [3:0]           GLITCH_CNT  = 4'(HIGH_MAX - 1);
  localparam logic [9:0]           RST_TICKS   = 10'(RESET_DELAY);
  localparam logic [BUFFER_BITS:0] LAST_ADDR   = (BUFFER_BITS + 1)'(BUFFER_END);

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  logic                   sync1_q, s_q, s_d_q;
  logic [1:0]             state_q, state_d;
  logic [3:0]             highCnt_q, highCnt_d;
  logic [9:0]             lowCnt_q, lowCnt_d;
  logic [2:0]             bitCnt_q, bitCnt_d;
  logic [6:0]             shift_q, shift_d;
  logic [BUFFER_BITS:0]   byteCnt_q, byteCnt_d;
  logic                   pixWrite_q, pixWrite_d;
  logic [BUFFER_BITS-1:0] pixAddr_q, pixAddr_d;
  logic [7:0]             pixData_q, pixData_d;
  logic                   frameDone_q, frameDone_d;
  logic [BUFFER_BITS:0]   frameBytes_q, frameBytes_d;
  logic                   errOverflow_q, errOverflow_d;
  logic                   errGlitch_q, errGlitch_d;

  logic                   rise, fall, bitVal;
  logic [9:0]             lowInc;
  logic [7:0]             newByte;

  // Synchronizer and edge-detect stage
  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      s_d_q   <= 1'b0;
    end else begin
      sync1_q <= neoDataIn;
      s_q     <= sync1_q;
      s_d_q   <= s_q;
    end
  end

  assign rise    = s_q & ~s_d_q;
  assign fall    = ~s_q & s_d_q;
  assign lowInc  = lowCnt_q + 10'd1;
  assign bitVal  = (highCnt_q >= BIT_ONE_CNT);
  assign newByte = {shift_q, bitVal};

  // Decode stage
  always_comb begin
    state_d       = state_q;
    highCnt_d     = highCnt_q;
    lowCnt_d      = lowCnt_q;
    bitCnt_d      = bitCnt_q;
    shift_d       = shift_q;
    byteCnt_d     = byteCnt_q;
    pixWrite_d    = 1'b0;
    pixAddr_d     = pixAddr_q;
    pixData_d     = pixData_q;
    frameDone_d   = 1'b0;
    frameBytes_d  = frameBytes_q;
    errOverflow_d = errOverflow_q;
    errGlitch_d   = errGlitch_q;

    case (state_q)
      ST_ARM: begin
        // Only a full reset-length low proves we are between frames.
        if (s_q) begin
          lowCnt_d = 10'd0;
        end else if (lowInc == RST_TICKS) begin
          lowCnt_d = 10'd0;
          state_d  = ST_IDLE;
        end else begin
          lowCnt_d = lowInc;
        end
      end

      ST_IDLE: begin
        if (rise) begin
          errOverflow_d = 1'b0;
          errGlitch_d   = 1'b0;
          byteCnt_d     = '0;
          bitCnt_d      = 3'd0;
          shift_d       = 7'd0;
          highCnt_d     = 4'd0;
          state_d       = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (fall) begin
          shift_d  = newByte[6:0];
          bitCnt_d = bitCnt_q + 3'd1;
          lowCnt_d = 10'd0;
          state_d  = ST_LOW;
          if (bitCnt_q == 3'd7) begin
            if (byteCnt_q <= LAST_ADDR) begin
              pixWrite_d = 1'b1;
              pixAddr_d  = byteCnt_q[BUFFER_BITS-1:0];
              pixData_d  = newByte;
              byteCnt_d  = byteCnt_q + 1'b1;
            end else begin
              errOverflow_d = 1'b1;
            end
          end
        end else if (s_q) begin
          if (highCnt_q >= GLITCH_CNT) begin
            errGlitch_d = 1'b1;
            lowCnt_d    = 10'd0;
            state_d     = ST_ARM;
          end else begin
            highCnt_d = sat_inc4(highCnt_q);
          end
        end
      end

      default: begin  // ST_LOW
        if (rise) begin
          highCnt_d = 4'd0;
          state_d   = ST_HIGH;
        end else if (lowInc == RST_TICKS) begin
          // End of frame: any partial byte is dropped here.
          frameDone_d  = 1'b1;
          frameBytes_d = byteCnt_q;
          bitCnt_d     = 3'd0;
          shift_d      = 7'd0;
          lowCnt_d     = 10'd0;
          state_d      = ST_IDLE;
        end else begin
          lowCnt_d = lowInc;
        end
      end
    endcase
  end

  // Output register stage
  always_ff @(posedge clk7mhz or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_ARM;
      highCnt_q     <= 4'd0;
      lowCnt_q      <= 10'd0;
      bitCnt_q      <= 3'd0;
      shift_q       <= 7'd0;
      byteCnt_q     <= '0;
      pixWrite_q    <= 1'b0;
      pixAddr_q     <= '0;
      pixData_q     <= 8'd0;
      frameDone_q   <= 1'b0;
      frameBytes_q  <= '0;
      errOverflow_q <= 1'b0;
      errGlitch_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      highCnt_q     <= highCnt_d;
      lowCnt_q      <= lowCnt_d;
      bitCnt_q      <= bitCnt_d;
      shift_q       <= shift_d;
      byteCnt_q     <= byteCnt_d;
      pixWrite_q    <= pixWrite_d;
      pixAddr_q     <= pixAddr_d;
      pixData_q     <= pixData_d;
      frameDone_q   <= frameDone_d;
      frameBytes_q  <= frameBytes_d;
      errOverflow_q <= errOverflow_d;
      errGlitch_q   <= errGlitch_d;
    end
  end

  assign pix.pixWrite = pixWrite_q;
  assign pix.pixAddr  = pixAddr_q;
  assign pix.pixData  = pixData_q;
  assign frameDone    = frameDone_q;
  assign frameBytes   = frameBytes_q;
  assign rxActive     = (state_q == ST_HIGH) || (state_q == ST_LOW);
  assign errOverflow  = errOverflow_q;
  assign errGlitch    = errGlitch_q;

endmodule

// File: tb/tb_anton_neopixel_rx.sv
// ----------------------------------------------------------------------------
// tb_anton_neopixel_rx
// Directed bench for anton_neopixel_rx with default parameters
// (BUFFER_END=31, RESET_DELAY=350, BIT_THRESHOLD=4, HIGH_MAX=7).
// A table of single-frame vectors is applied in a loop; overflow, glitch,
// start-up and mid-frame reset are hand-written sequences.
// ----------------------------------------------------------------------------
module tb_anton_neopixel_rx;

  logic       clk = 1'b0;
  logic       rstn;
  logic       line;
  logic       frameDone;
  logic [5:0] frameBytes;
  logic       rxActive;
  logic       errOverflow;
  logic       errGlitch;

  anton_neopixel_rx_if #(.ADDR_W(5)) pix_if ();

  anton_neopixel_rx dut (
    .clk7mhz     (clk),
    .rstn        (rstn),
    .neoDataIn   (line),
    .pix         (pix_if),
    .frameDone   (frameDone),
    .frameBytes  (frameBytes),
    .rxActive    (rxActive),
    .errOverflow (errOverflow),
    .errGlitch   (errGlitch)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] addr_q[$];
  logic [7:0] data_q[$];
  int         done_cnt = 0;
  bit         rx_seen  = 1'b0;

  // Record every write strobe and frameDone cycle away from the active edge.
  always @(negedge clk) begin
    if (rstn) begin
      if (pix_if.pixWrite) begin
        addr_q.push_back(8'(pix_if.pixAddr));
        data_q.push_back(pix_if.pixData);
      end
      if (frameDone) done_cnt++;
      if (rxActive) rx_seen = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    addr_q.delete();
    data_q.delete();
    done_cnt = 0;
    rx_seen  = 1'b0;
  endtask

  // Nominal transmitter timing: 0 = 2 high + 6 low, 1 = 5 high + 3 low.
  task automatic send_bit(input logic b);
    line = 1'b1;
    tick(b ? 5 : 2);
    line = 1'b0;
    tick(b ? 3 : 6);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_bits(input int n, input logic [15:0] pat);
    for (int i = 0; i < n; i++) send_bit(pat[15-i]);
  endtask

  task automatic low(input int n);
    line = 1'b0;
    tick(n);
  endtask

  typedef struct {
    int         nbits;
    logic [15:0] pat;
    int         exp_wr;
    logic [7:0] exp_d0;
    logic [7:0] exp_d1;
    int         exp_bytes;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] tail;

    vecs[0] = '{8,  16'hA500, 1, 8'hA5, 8'h00, 1};
    vecs[1] = '{8,  16'h0000, 1, 8'h00, 8'h00, 1};
    vecs[2] = '{8,  16'h3C00, 1, 8'h3C, 8'h00, 1};
    vecs[3] = '{12, 16'hFFF0, 1, 8'hFF, 8'h00, 1};  // 0xFF then 4 ones, dropped
    vecs[4] = '{3,  16'hA000, 0, 8'h00, 8'h00, 0};  // no complete byte
    vecs[5] = '{16, 16'h1234, 2, 8'h12, 8'h34, 2};

    // Reset state
    rstn = 1'b0;
    line = 1'b0;
    tick(3);
    check("rst pixWrite",    32'(pix_if.pixWrite), 0);
    check("rst frameDone",   32'(frameDone), 0);
    check("rst frameBytes",  32'(frameBytes), 0);
    check("rst rxActive",    32'(rxActive), 0);
    check("rst errOverflow", 32'(errOverflow), 0);
    check("rst errGlitch",   32'(errGlitch), 0);

    // Start-up with the line already toggling: must not decode anything
    line = 1'b1;
    tick(1);
    rstn = 1'b1;
    clear_log();
    for (int i = 0; i < 200; i++) begin
      line = ((i / 3) % 2 == 0);
      tick(1);
    end
    low(360);
    check("startup writes",   32'(addr_q.size()), 0);
    check("startup rxActive", 32'(rx_seen), 0);
    check("startup done",     32'(done_cnt), 0);

    // Table of single-frame vectors
    for (int v = 0; v < 6; v++) begin
      clear_log();
      send_bits(vecs[v].nbits, vecs[v].pat);
      low(400);
      check($sformatf("v%0d writes", v), 32'(addr_q.size()), 32'(vecs[v].exp_wr));
      for (int k = 0; k < addr_q.size() && k < 2; k++) begin
        check($sformatf("v%0d addr%0d", v, k), 32'(addr_q[k]), 32'(k));
        check($sformatf("v%0d data%0d", v, k), 32'(data_q[k]),
              32'((k == 0) ? vecs[v].exp_d0 : vecs[v].exp_d1));
      end
      check($sformatf("v%0d frameDone", v),  32'(done_cnt), 1);
      check($sformatf("v%0d frameBytes", v), 32'(frameBytes), 32'(vecs[v].exp_bytes));
      check($sformatf("v%0d errOverflow", v), 32'(errOverflow), 0);
      check($sformatf("v%0d errGlitch", v),   32'(errGlitch), 0);
      check($sformatf("v%0d rxActive", v),    32'(rxActive), 0);
    end

    // Overflow: 33 bytes into a 32-byte buffer
    clear_log();
    for (int b = 0; b < 33; b++) send_byte(8'(b));
    low(400);
    check("ovf writes", 32'(addr_q.size()), 32);
    for (int k = 0; k < addr_q.size(); k++) begin
      check($sformatf("ovf addr%0d", k), 32'(addr_q[k]), 32'(k));
      check($sformatf("ovf data%0d", k), 32'(data_q[k]), 32'(k));
    end
    check("ovf errOverflow", 32'(errOverflow), 1);
    check("ovf frameBytes",  32'(frameBytes), 32);
    check("ovf frameDone",   32'(done_cnt), 1);

    // Glitch: 9-tick high pulse mid-byte, then traffic that must be ignored
    clear_log();
    send_bit(1'b1);
    send_bit(1'b0);
    line = 1'b1;
    tick(9);
    line = 1'b0;
    tick(3);
    send_byte(8'hFF);
    low(20);
    check("glitch errGlitch",   32'(errGlitch), 1);
    check("glitch writes",      32'(addr_q.size()), 0);
    check("glitch frameDone",   32'(done_cnt), 0);
    check("glitch frameBytes",  32'(frameBytes), 32);
    check("glitch errOverflow", 32'(errOverflow), 0);
    check("glitch rxActive",    32'(rxActive), 0);
    low(360);
    check("glitch sticky", 32'(errGlitch), 1);
    // Next frame: first bit by hand so errGlitch can be seen clearing
    line = 1'b1;
    tick(4);
    check("recover errGlitch", 32'(errGlitch), 0);
    check("recover rxActive",  32'(rxActive), 1);
    tick(1);
    line = 1'b0;
    tick(3);
    tail = 8'hB5;
    for (int i = 6; i >= 0; i--) send_bit(tail[i]);
    low(400);
    check("recover writes", 32'(addr_q.size()), 1);
    if (addr_q.size() > 0) begin
      check("recover addr", 32'(addr_q[0]), 0);
      check("recover data", 32'(data_q[0]), 32'h0B5);
    end
    check("recover frameBytes", 32'(frameBytes), 1);
    check("recover frameDone",  32'(done_cnt), 1);

    // Reset in the middle of the second byte
    clear_log();
    send_byte(8'h11);
    send_bits(4, 16'h2000);
    line = 1'b1;
    tick(2);
    rstn = 1'b0;
    #1;
    check("midrst pixWrite",    32'(pix_if.pixWrite), 0);
    check("midrst frameDone",   32'(frameDone), 0);
    check("midrst frameBytes",  32'(frameBytes), 0);
    check("midrst rxActive",    32'(rxActive), 0);
    check("midrst errOverflow", 32'(errOverflow), 0);
    check("midrst errGlitch",   32'(errGlitch), 0);
    tick(3);
    line = 1'b0;
    tick(2);
    rstn = 1'b1;
    check("midrst writes", 32'(addr_q.size()), 1);
    check("midrst done",   32'(done_cnt), 0);
    // Too-short low after reset: frame must be ignored
    clear_log();
    low(100);
    send_byte(8'h3C);
    low(50);
    check("unarmed writes", 32'(addr_q.size()), 0);
    low(360);
    send_byte(8'h3C);
    low(400);
    check("rearm writes", 32'(addr_q.size()), 1);
    if (addr_q.size() > 0) begin
      check("rearm addr", 32'(addr_q[0]), 0);
      check("rearm data", 32'(data_q[0]), 32'h03C);
    end
    check("rearm frameBytes", 32'(frameBytes), 1);
    check("rearm frameDone",  32'(done_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
